// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx -- memory-mapped UART transmitter with a small transmit FIFO.
//
// A store to TX_ADDR enqueues din[7:0]; a store to STATUS_ADDR clears the
// sticky overrun flag. Frames are 8N1 (start, 8 data bits LSB first, stop),
// each bit held for CLKS_PER_BIT clocks. Queued bytes go out back-to-back.
//
// Ports
//   clock      : single rising-edge clock
//   clear      : synchronous active-high reset
//   wren       : store strobe from the MEM stage
//   addr[7:0]  : word address of the store / status read
//   din[31:0]  : store data (only [7:0] is used for transmit)
//   dout[31:0] : {29'b0, overrun, fifo_full, busy} when addr == STATUS_ADDR, else 0
//   tx         : registered serial output, idles high
//   busy       : frame in progress or FIFO non-empty
//   fifo_full  : FIFO holds FIFO_DEPTH entries
module mmio_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 4,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter logic [7:0]  TX_ADDR      = 8'hFF,
   parameter logic [7:0]  STATUS_ADDR  = 8'hFE
) (
   input  logic        clock,
   input  logic        clear,
   input  logic        wren,
   input  logic [7:0]  addr,
   input  logic [31:0] din,
   output logic [31:0] dout,
   output logic        tx,
   output logic        busy,
   output logic        fifo_full
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t            state;
   logic [BAUD_W-1:0] baud_cnt;
   logic [2:0]        bit_idx;
   logic [7:0]        shreg;

   logic [7:0]        fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              overrun;

   logic              tx_sel;
   logic              st_sel;
   logic              fifo_empty;
   logic              push;
   logic              drop;
   logic              pop;
   logic              baud_done;

   // Upper store bits carry no meaning for the transmitter.
   logic [23:0]       din_unused;
   assign din_unused = din[31:8];

   // Decode, FIFO handshakes and status read
   always_comb begin
      tx_sel     = wren && (addr == TX_ADDR);
      st_sel     = wren && (addr == STATUS_ADDR);
      fifo_empty = (count == '0);
      fifo_full  = (count == DEPTH_CNT);
      // fullness is judged on pre-edge state: a same-edge pop does not rescue it
      push       = tx_sel && !fifo_full;
      drop       = tx_sel && fifo_full;
      baud_done  = (baud_cnt == BAUD_LAST);
      // head is taken when idle, or at the last stop-bit cycle for gapless frames
      pop        = !fifo_empty && ((state == IDLE) || ((state == STOP) && baud_done));
      busy       = (state != IDLE) || !fifo_empty;
      dout       = 32'b0;
      if (addr == STATUS_ADDR) begin
         dout = {29'b0, overrun, fifo_full, busy};
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clock) begin
      if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // FIFO storage (data only, never reset)
   always_ff @(posedge clock) begin
      if (push) begin
         fifo_mem[wr_ptr] <= din[7:0];
      end
   end

   // Sticky overrun: a status write wins over a drop at the same edge
   always_ff @(posedge clock) begin
      if (clear) begin
         overrun <= 1'b0;
      end else if (st_sel) begin
         overrun <= 1'b0;
      end else if (drop) begin
         overrun <= 1'b1;
      end
   end

   // Transmit FSM; tx is driven directly from this register
   always_ff @(posedge clock) begin
      if (clear) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= 3'd0;
         tx       <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               baud_cnt <= '0;
               tx       <= 1'b1;
               if (pop) begin
                  shreg <= fifo_mem[rd_ptr];
                  state <= START;
                  tx    <= 1'b0;
               end
            end

            START: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  bit_idx  <= 3'd0;
                  tx       <= shreg[0];
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            DATA: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     tx      <= shreg[bit_idx + 3'd1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            STOP: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  if (pop) begin
                     // next byte starts immediately, no idle bit between frames
                     shreg <= fifo_mem[rd_ptr];
                     tx    <= 1'b0;
                     state <= START;
                  end else begin
                     tx    <= 1'b1;
                     state <= IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            default: begin
               state    <= IDLE;
               baud_cnt <= '0;
               tx       <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx -- self-checking bench for mmio_uart_tx.
// A queue-based reference model tracks FIFO contents, the frame timer and
// the overrun flag; the expected tx level is derived from the position
// inside the current 10-bit frame.
module tb_mmio_uart_tx;

   localparam int         CPB   = 4;
   localparam int         DEPTH = 4;
   localparam int         FRAME = 10 * CPB;
   localparam logic [7:0] TXA   = 8'hFF;
   localparam logic [7:0] STA   = 8'hFE;

   logic        clock = 1'b0;
   logic        clear;
   logic        wren;
   logic [7:0]  addr;
   logic [31:0] din;
   logic [31:0] dout;
   logic        tx;
   logic        busy;
   logic        fifo_full;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int ovf_start = 0;

   // reference model state
   logic [7:0] mq[$];
   logic [7:0] m_cur = 8'h00;
   int         m_timer = 0;
   logic       m_ovr = 1'b0;

   always #5 clock = ~clock;

   mmio_uart_tx #(
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH  (DEPTH),
      .TX_ADDR     (TXA),
      .STATUS_ADDR (STA)
   ) dut (
      .clock    (clock),
      .clear    (clear),
      .wren     (wren),
      .addr     (addr),
      .din      (din),
      .dout     (dout),
      .tx       (tx),
      .busy     (busy),
      .fifo_full(fifo_full)
   );

   function automatic logic m_tx_exp();
      int e;
      int b;
      if (m_timer == 0) return 1'b1;
      e = FRAME - m_timer;
      b = e / CPB;
      if (b == 0) return 1'b0;
      if (b <= 8) return m_cur[b-1];
      return 1'b1;
   endfunction

   function automatic logic [34:0] exp_obs();
      logic        mb;
      logic        mf;
      logic [31:0] d;
      mb = (m_timer != 0) || (mq.size() != 0);
      mf = (mq.size() == DEPTH);
      d  = (addr == STA) ? {29'b0, m_ovr, mf, mb} : 32'b0;
      return {m_tx_exp(), mb, mf, d};
   endfunction

   // drive one cycle, advance the model at the edge, settle past the edge
   task automatic tick(input logic c, input logic w, input logic [7:0] a, input logic [31:0] d);
      logic full;
      logic drop;
      clear = c;
      wren  = w;
      addr  = a;
      din   = d;
      @(posedge clock);
      drop = 1'b0;
      if (c) begin
         mq.delete();
         m_timer = 0;
         m_ovr   = 1'b0;
      end else begin
         full = (mq.size() == DEPTH);
         if ((mq.size() > 0) && (m_timer <= 1)) begin
            m_cur   = mq.pop_front();
            m_timer = FRAME;
         end else if (m_timer > 0) begin
            m_timer--;
         end
         if (w && (a == TXA)) begin
            if (!full) mq.push_back(d[7:0]);
            else       drop = 1'b1;
         end
         if (w && (a == STA)) m_ovr = 1'b0;
         else if (drop)       m_ovr = 1'b1;
      end
      cyc++;
      #1;
   endtask

   task automatic test_reset();
      tick(1'b1, 1'b0, STA, 32'h0);
      tick(1'b1, 1'b1, STA, 32'hFFFF_FFFF);
      checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", tx); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (fifo_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", fifo_full); end
      checks++; if (dout !== 32'h0) begin failures++; $display("FAIL reset_dout got=%h exp=0", dout); end
   endtask

   task automatic test_single_byte();
      int   start;
      int   e;
      logic eb;
      start = cyc;
      tick(1'b0, 1'b1, TXA, 32'hABCD_EF41);
      checks++; if (tx !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL single_edge1 tx=%b busy=%b exp tx=1 busy=1", tx, busy); end
      for (int k = 0; k < 46; k++) begin
         tick(1'b0, 1'b0, STA, 32'h0);
         e = cyc - start;
         checks++;
         if ({tx, busy, fifo_full, dout} !== exp_obs()) begin
            failures++; $display("FAIL single_model edge=%0d got=%h exp=%h", e, {tx, busy, fifo_full, dout}, exp_obs());
         end
         if (e >= 2 && e <= 5) eb = 1'b0;
         else if (e >= 6 && e <= 37) eb = 1'((8'h41 >> ((e - 6) / 4)) & 8'h01);
         else eb = 1'b1;
         checks++; if (tx !== eb) begin failures++; $display("FAIL single_tx edge=%0d got=%b exp=%b", e, tx, eb); end
         if (e == 41) begin
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy41 got=%b exp=1", busy); end
         end
         if (e == 42) begin
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy42 got=%b exp=0", busy); end
         end
      end
   endtask

   task automatic test_overflow();
      ovf_start = cyc;
      for (int i = 0; i < 6; i++) begin
         tick(1'b0, 1'b1, TXA, 32'h30 + i);
         checks++;
         if ({tx, busy, fifo_full, dout} !== exp_obs()) begin
            failures++; $display("FAIL ovf_model push=%0d got=%h exp=%h", i, {tx, busy, fifo_full, dout}, exp_obs());
         end
         if (i == 3) begin
            checks++; if (fifo_full !== 1'b0) begin failures++; $display("FAIL ovf_full4 got=%b exp=0", fifo_full); end
         end
         if (i == 4) begin
            checks++; if (fifo_full !== 1'b1) begin failures++; $display("FAIL ovf_full5 got=%b exp=1", fifo_full); end
         end
      end
      tick(1'b0, 1'b0, STA, 32'h0);
      checks++; if (dout !== 32'h7) begin failures++; $display("FAIL ovf_status got=%h exp=00000007", dout); end
   endtask

   task automatic test_overrun_clear();
      int fall;
      tick(1'b0, 1'b1, STA, $urandom);
      tick(1'b0, 1'b0, STA, 32'h0);
      checks++; if (dout !== 32'h3) begin failures++; $display("FAIL ovr_clear_status got=%h exp=00000003", dout); end
      fall = -1;
      for (int k = 0; k < 400 && fall < 0; k++) begin
         tick(1'b0, 1'b0, STA, 32'h0);
         checks++;
         if ({tx, busy, fifo_full, dout} !== exp_obs()) begin
            failures++; $display("FAIL ovr_drain_model cyc=%0d got=%h exp=%h", cyc, {tx, busy, fifo_full, dout}, exp_obs());
         end
         if (!busy) fall = cyc - ovf_start;
      end
      checks++; if (fall !== 202) begin failures++; $display("FAIL ovr_drain_fall got=%0d exp=202", fall); end
   endtask

   task automatic test_reset_mid_frame();
      tick(1'b0, 1'b1, TXA, 32'h55);
      for (int k = 0; k < 15; k++) tick(1'b0, 1'b0, 8'h00, 32'h0);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_mid_busy_before got=%b exp=1", busy); end
      tick(1'b1, 1'b1, STA, 32'h0);
      checks++; if (tx !== 1'b1) begin failures++; $display("FAIL rst_mid_tx got=%b exp=1", tx); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
      checks++; if (dout !== 32'h0) begin failures++; $display("FAIL rst_mid_dout got=%h exp=0", dout); end
      tick(1'b1, 1'b1, TXA, 32'h77);
      checks++; if (busy !== 1'b0 || fifo_full !== 1'b0) begin failures++; $display("FAIL rst_prio busy=%b full=%b exp 0 0", busy, fifo_full); end
      tick(1'b0, 1'b1, TXA, 32'h0A);
      for (int k = 0; k < 45; k++) begin
         tick(1'b0, 1'b0, STA, 32'h0);
         checks++;
         if ({tx, busy, fifo_full, dout} !== exp_obs()) begin
            failures++; $display("FAIL rst_after_model cyc=%0d got=%h exp=%h", cyc, {tx, busy, fifo_full, dout}, exp_obs());
         end
      end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_after_idle got=%b exp=0", busy); end
   endtask

   task automatic test_wrap();
      int pushed;
      pushed = 0;
      for (int k = 0; k < 2000 && (pushed < 10 || busy); k++) begin
         if (pushed < 10 && !fifo_full) begin
            tick(1'b0, 1'b1, TXA, $urandom);
            pushed++;
         end else begin
            tick(1'b0, 1'b0, STA, 32'h0);
         end
         checks++;
         if ({tx, busy, fifo_full, dout} !== exp_obs()) begin
            failures++; $display("FAIL wrap_model cyc=%0d got=%h exp=%h", cyc, {tx, busy, fifo_full, dout}, exp_obs());
         end
      end
      checks++; if (pushed !== 10 || busy !== 1'b0) begin failures++; $display("FAIL wrap_done pushed=%0d busy=%b exp 10 0", pushed, busy); end
      tick(1'b0, 1'b0, STA, 32'h0);
      checks++; if (dout[2] !== 1'b0) begin failures++; $display("FAIL wrap_overrun got=%b exp=0", dout[2]); end
   endtask

   task automatic test_addr_decode();
      tick(1'b0, 1'b1, 8'hFD, 32'h41);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL decode_busy got=%b exp=0", busy); end
      checks++; if (dout !== 32'h0) begin failures++; $display("FAIL decode_dout got=%h exp=0", dout); end
      for (int k = 0; k < 6; k++) begin
         tick(1'b0, 1'b0, 8'hFD, 32'h0);
         checks++; if (tx !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL decode_idle tx=%b busy=%b exp 1 0", tx, busy); end
      end
   endtask

   task automatic test_random();
      int         r;
      logic       c;
      logic       w;
      logic [7:0] a;
      for (int k = 0; k < 3000; k++) begin
         r = int'($urandom_range(0, 99));
         c = (r == 0);
         w = ($urandom_range(0, 1) == 1);
         r = int'($urandom_range(0, 99));
         if (r < 8)       a = TXA;
         else if (r < 12) a = STA;
         else if (r < 60) a = 8'($urandom);
         else             a = STA;
         if (a == STA && $urandom_range(0, 3) != 0) w = 1'b0;
         tick(c, w, a, $urandom);
         checks++;
         if ({tx, busy, fifo_full, dout} !== exp_obs()) begin
            failures++; $display("FAIL random_model cyc=%0d got=%h exp=%h", cyc, {tx, busy, fifo_full, dout}, exp_obs());
         end
      end
   endtask

   initial begin
      clear = 1'b1;
      wren  = 1'b0;
      addr  = 8'h00;
      din   = 32'h0;
      test_reset();
      test_single_byte();
      test_overflow();
      test_overrun_clear();
      test_reset_mid_frame();
      test_wrap();
      test_addr_decode();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
